// File: rtl/sequence_gen.sv
// Pseudo-random 16-colour sequence generator for a memory game.
// A Galois LFSR, optionally reseeded from a free-running entropy counter, fills one slot per cycle.
module sequence_gen #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned NO_REPEAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_gen,
    input  logic        seed_strobe,
    output logic [31:0] seq_out_gen,
    output logic        seq_valid,
    output logic        busy_gen,
    output logic        complete_gen
);

    typedef enum logic [1:0] {
        StIdle,
        StGen,
        StDone
    } state_e;

    localparam logic [15:0] LfsrTaps = 16'hB400;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] entropy_q, entropy_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] seq_q, seq_d;
    logic        valid_q, valid_d;
    logic [1:0]  prev_q, prev_d;

    logic [15:0] seed_mix;
    logic [15:0] seed_load;
    logic [15:0] lfsr_step;
    logic [1:0]  raw_col;
    logic [1:0]  emit_col;

    // An all-zero LFSR would lock up, so that mix falls back to the fixed seed.
    assign seed_mix  = entropy_q ^ SEED;
    assign seed_load = (seed_mix == 16'h0000) ? SEED : seed_mix;

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
    assign raw_col   = lfsr_q[1:0];

    always_comb begin
        emit_col = raw_col;
        if ((NO_REPEAT != 0) && (idx_q != 4'd0) && (raw_col == prev_q)) begin
            emit_col = raw_col + 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        entropy_d = entropy_q + 16'd1;
        idx_d     = idx_q;
        seq_d     = seq_q;
        valid_d   = valid_q;
        prev_d    = prev_q;

        unique case (state_q)
            StIdle: begin
                if (seed_strobe) begin
                    lfsr_d = seed_load;
                end
                if (en_gen) begin
                    seq_d   = 32'h0000_0000;
                    valid_d = 1'b0;
                    idx_d   = 4'd0;
                    state_d = StGen;
                end
            end
            StGen: begin
                seq_d[{idx_q, 1'b0} +: 2] = emit_col;
                prev_d = emit_col;
                lfsr_d = lfsr_step;
                idx_d  = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    valid_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            lfsr_q    <= SEED;
            entropy_q <= 16'h0000;
            idx_q     <= 4'd0;
            seq_q     <= 32'h0000_0000;
            valid_q   <= 1'b0;
            prev_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            entropy_q <= entropy_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            valid_q   <= valid_d;
            prev_q    <= prev_d;
        end
    end

    assign seq_out_gen  = seq_q;
    assign seq_valid    = valid_q;
    assign busy_gen     = (state_q == StGen);
    assign complete_gen = (state_q == StDone);

endmodule

// File: tb/tb_sequence_gen.sv
// Scoreboard bench for sequence_gen: three instances (default, no-repeat, seed 5) share stimulus.
module tb_sequence_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic en_gen = 1'b0;
    logic seed_strobe = 1'b0;

    logic [31:0] seq_a, seq_b, seq_c;
    logic        valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c;
    logic        complete_a, complete_b, complete_c;

    sequence_gen u_dflt (
        .clk(clk), .rst_n(rst_n), .en_gen(en_gen), .seed_strobe(seed_strobe),
        .seq_out_gen(seq_a), .seq_valid(valid_a), .busy_gen(busy_a), .complete_gen(complete_a)
    );

    sequence_gen #(.NO_REPEAT(1)) u_nrep (
        .clk(clk), .rst_n(rst_n), .en_gen(en_gen), .seed_strobe(seed_strobe),
        .seq_out_gen(seq_b), .seq_valid(valid_b), .busy_gen(busy_b), .complete_gen(complete_b)
    );

    sequence_gen #(.SEED(16'h0005)) u_seed5 (
        .clk(clk), .rst_n(rst_n), .en_gen(en_gen), .seed_strobe(seed_strobe),
        .seq_out_gen(seq_c), .seq_valid(valid_c), .busy_gen(busy_c), .complete_gen(complete_c)
    );

    typedef struct {
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] ent;
    logic [15:0] m_lfsr[3];
    logic [31:0] first_seq;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ent <= 16'h0000;
        else        ent <= ent + 16'd1;
    end

    function automatic logic [15:0] seed_of(input int i);
        return (i == 2) ? 16'h0005 : 16'hACE1;
    endfunction

    function automatic void gen_seq(input logic [15:0] l_in, input bit nr,
                                    output logic [31:0] seq, output logic [15:0] l_out);
        logic [15:0] l;
        logic [1:0]  c;
        logic [1:0]  prev;
        l = l_in;
        prev = 2'd0;
        seq = 32'h0;
        for (int i = 0; i < 16; i++) begin
            c = l[1:0];
            if (nr && i > 0 && c == prev) c = c + 2'd1;
            seq[2*i +: 2] = c;
            prev = c;
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        l_out = l;
    endfunction

    function automatic int count_repeats(input logic [31:0] seq);
        int n;
        n = 0;
        for (int i = 1; i < 16; i++) begin
            if (seq[2*i +: 2] == seq[2*(i-1) +: 2]) n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && complete_a) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_complete: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("seq_dflt", seq_a, mon_e.s0);
                check("seq_nrep", seq_b, mon_e.s1);
                check("seq_seed5", seq_c, mon_e.s2);
                check("done_latency", cyc, mon_e.cyc);
                check("valid_in_done", {29'b0, valid_a, valid_b, valid_c}, 32'h7);
                check("complete_all", {30'b0, complete_b, complete_c}, 32'h3);
                check("nrep_adjacent", count_repeats(seq_b), 32'h0);
            end
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        en_gen = 1'b0;
        seed_strobe = 1'b0;
        #1;
        check("rst_seq", seq_a | seq_b | seq_c, 32'h0);
        check("rst_flags", {23'b0, valid_a, valid_b, valid_c, busy_a, busy_b, busy_c,
                            complete_a, complete_b, complete_c}, 32'h0);
        sb.delete();
        for (int i = 0; i < 3; i++) m_lfsr[i] = seed_of(i);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic strobe_model();
        logic [15:0] mix;
        for (int i = 0; i < 3; i++) begin
            mix = ent ^ seed_of(i);
            m_lfsr[i] = (mix == 16'h0000) ? seed_of(i) : mix;
        end
    endtask

    task automatic start_run(input bit strobe);
        exp_t        e;
        logic [15:0] lo;
        @(negedge clk);
        if (strobe) strobe_model();
        gen_seq(m_lfsr[0], 1'b0, e.s0, lo);
        m_lfsr[0] = lo;
        gen_seq(m_lfsr[1], 1'b1, e.s1, lo);
        m_lfsr[1] = lo;
        gen_seq(m_lfsr[2], 1'b0, e.s2, lo);
        m_lfsr[2] = lo;
        e.cyc = cyc + 17;
        sb.push_back(e);
        en_gen = 1'b1;
        seed_strobe = strobe;
        @(negedge clk);
        en_gen = 1'b0;
        seed_strobe = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (complete_a) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no complete_gen in 40 cycles, expected one");
        end
        @(negedge clk);
        check("post_done", {29'b0, complete_a, busy_a, valid_a}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, expected finish");
        $fatal(1);
    end

    initial begin
        // Default seed run, then a back-to-back run continuing the stream.
        reset_dut();
        start_run(1'b0);
        wait_done();
        check("dflt_low_byte", {24'b0, seq_a[7:0]}, 32'h01);
        check("nrep_low_byte", {24'b0, seq_b[7:0]}, 32'h11);
        first_seq = seq_a;

        start_run(1'b0);
        repeat (3) @(negedge clk);
        check("b2b_mid_flags", {30'b0, valid_a, busy_a}, 32'h1);
        wait_done();
        check("b2b_differs", {31'b0, seq_a != first_seq}, 32'h1);

        // Start and reseed requests during GEN must be ignored.
        start_run(1'b0);
        repeat (4) @(negedge clk);
        en_gen = 1'b1;
        seed_strobe = 1'b1;
        @(negedge clk);
        en_gen = 1'b0;
        seed_strobe = 1'b0;
        wait_done();

        // Abort mid-run, then the default-seed sequence must reappear.
        start_run(1'b0);
        repeat (7) @(negedge clk);
        check("pre_abort_busy", {31'b0, busy_a}, 32'h1);
        reset_dut();
        repeat (3) @(negedge clk);
        check("abort_no_valid", {29'b0, valid_a, complete_a, busy_a}, 32'h0);
        start_run(1'b0);
        wait_done();
        check("rerun_matches", seq_a, first_seq);
        check("rerun_low_byte", {24'b0, seq_a[7:0]}, 32'h01);

        // Reseed when entropy equals SEED of the seed-5 instance.
        reset_dut();
        for (int i = 0; i < 20 && ent != 16'd5; i++) @(negedge clk);
        strobe_model();
        seed_strobe = 1'b1;
        @(negedge clk);
        seed_strobe = 1'b0;
        start_run(1'b0);
        wait_done();
        check("seed5_low_byte", {24'b0, seq_c[7:0]}, 32'h19);
        check("seed5_nonzero", {31'b0, seq_c != 32'h0}, 32'h1);

        // Reseed and start on the same edge.
        repeat (2) @(negedge clk);
        start_run(1'b1);
        wait_done();

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sequence_gen.md
SEQUENCE_GEN -- requirements
Module: sequence_gen

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value and the fallback seed.
REQ-002 SHALL have parameter NO_REPEAT, default 0; when 1, no emitted colour equals the previously emitted colour.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en_gen, input, 1 bit: start request, sampled only in IDLE.
REQ-006 SHALL have port seed_strobe, input, 1 bit: reseed request (player button entropy), sampled only in IDLE.
REQ-007 SHALL have port seq_out_gen, output, 32 bits: 16 colours packed LSB-first; colour i occupies [2i+1:2i].
REQ-008 SHALL have port seq_valid, output, 1 bit: seq_out_gen holds a complete sequence.
REQ-009 SHALL have port busy_gen, output, 1 bit: high while in GEN.
REQ-010 SHALL have port complete_gen, output, 1 bit: one-cycle done pulse.

Function
REQ-011 SHALL keep a 16-bit entropy counter that increments every cycle and wraps 0xFFFF->0x0000.
REQ-012 SHALL use a 16-bit Galois LFSR step: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 16'h0000).
REQ-013 SHALL use an FSM with states IDLE, GEN and DONE only.
REQ-014 In IDLE, seed_strobe=1 SHALL load lfsr <= entropy ^ SEED; if that result is 0x0000, it SHALL load SEED instead.
REQ-015 In IDLE, en_gen=1 SHALL take these actions on one edge: clear seq_out_gen to 0, clear seq_valid, set idx to 0, and enter GEN.
REQ-016 If seed_strobe and en_gen are both high in IDLE, SHALL apply the reseed and the start on the same edge; generation then uses the new seed.
REQ-017 Each GEN cycle SHALL take raw colour c = lfsr[1:0], write the emitted colour into slot idx, advance the LFSR one step and increment idx.
REQ-018 When NO_REPEAT=1, idx>0 and c equals the previously emitted colour, SHALL emit (c+1) mod 4; otherwise SHALL emit c.
REQ-019 After writing slot 15, SHALL enter DONE; the 4-bit idx SHALL wrap to 0.
REQ-020 In DONE, complete_gen and seq_valid SHALL be 1; on the next edge complete_gen SHALL return to 0 and the FSM SHALL return to IDLE.
REQ-021 seq_valid SHALL stay 1 in IDLE until the next accepted en_gen.
REQ-022 seq_out_gen SHALL remain stable whenever seq_valid=1.
REQ-023 Latency: with en_gen sampled at edge k, edges k+1..k+16 SHALL write slots 0..15; complete_gen SHALL be high for exactly the cycle after edge k+16.
REQ-024 en_gen and seed_strobe SHALL be ignored in GEN and in DONE; no restart and no reseed.
REQ-025 busy_gen SHALL be 1 exactly while the state is GEN.

Reset
REQ-026 When rst_n=0, the block SHALL immediately apply: state=IDLE, lfsr=SEED, entropy=0, idx=0, seq_out_gen=0, seq_valid=0, busy_gen=0, complete_gen=0.
REQ-027 Reset asserted mid-GEN SHALL abort the run; after release the block is in IDLE with seq_valid=0 and no complete_gen pulse.
REQ-028 Operation SHALL resume on the first rising edge after rst_n rises.

Verification
REQ-029 Default SEED, NO_REPEAT=0, no strobe, en_gen pulse -> seq_out_gen[7:0]=8'h01; complete_gen high for exactly 1 cycle, 17 cycles after en_gen was sampled.
REQ-030 Same stimulus with NO_REPEAT=1 -> seq_out_gen[7:0]=8'h11; all 16 slots differ from the preceding slot.
REQ-031 SEED=16'h0005, seed_strobe when entropy=0x0005 -> lfsr loads 0x0005, not 0x0000; a following run produces a nonzero sequence.
REQ-032 en_gen and seed_strobe pulsed during GEN -> no restart, lfsr trajectory unchanged, exactly one complete_gen pulse.
REQ-033 rst_n low at slot 7 of GEN -> all outputs are 0 immediately; the next run from the default seed reproduces the sequence from REQ-029.
REQ-034 Two back-to-back runs without reseed -> the second sequence continues the LFSR stream; seq_valid is low from the second en_gen edge until its DONE.
